// File: rtl/fmad_sched.sv
// fmad_sched: FMA issue scheduler with writeback-slot reservation and a credit-controlled in-order result FIFO
module fmad_sched #(
    parameter int OBUF_DEPTH = 4,
    parameter int TAG_W      = 4,
    parameter int LAT_D      = 5,
    parameter int LAT_S      = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic [31:0]      req_command,
    input  logic [TAG_W-1:0] req_tag,
    output logic             req_rdy,
    output logic [3:0]       mul_en,
    output logic             asel_en,
    output logic             asft_en0,
    output logic [3:0]       asft_en1,
    output logic [1:0]       add1_en,
    output logic [1:0]       add2_en,
    output logic             rslt_vld,
    input  logic             rslt_rdy,
    output logic [TAG_W-1:0] rslt_tag,
    output logic             rslt_sp,
    output logic             rslt_ill,
    output logic             busy
);
    localparam int AW = $clog2(OBUF_DEPTH);
    localparam int CW = $clog2(OBUF_DEPTH + 1);
    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic             sp;
        logic             ill;
    } ent_t;
    logic is_d, is_s, acc, pop, wr;
    ent_t new_ent;
    logic [LAT_D-1:0] rsv_v_q, rsv_v_d;
    ent_t [LAT_D-1:0] rsv_e_q, rsv_e_d;
    logic [3:0] d_q, d_d;
    logic [2:0] s_q, s_d;
    ent_t [OBUF_DEPTH-1:0] mem_q;
    logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0] cnt_q, cnt_d, cred_q, cred_d;

    assign is_d = req_command == 32'd0;
    assign is_s = req_command == 32'd1;
    assign new_ent = '{tag: req_tag, sp: is_s, ill: !(is_d || is_s)};
    // An FMAD lands one slot past anything already reserved, so only FMAS/illegal can collide
    assign req_rdy = !reset && cred_q < CW'(OBUF_DEPTH) && (is_d || !rsv_v_q[LAT_S]);
    assign acc = req && req_rdy;
    assign wr = rsv_v_q[0];
    assign pop = rslt_vld && rslt_rdy;
    assign busy = cred_q != '0;
    assign rslt_vld = cnt_q != '0;
    assign {rslt_tag, rslt_sp, rslt_ill} = mem_q[rp_q];
    assign mul_en = {d_q[0] | s_q[0], d_q[0], d_q[0], d_q[0] | s_q[0]};
    assign asel_en = d_q[1] | s_q[1];
    assign asft_en0 = asel_en;
    assign asft_en1 = {d_q[2], d_q[2], d_q[2] | s_q[2], d_q[2] | s_q[2]};
    assign add1_en = {d_q[2], d_q[2] | s_q[2]};
    assign add2_en = {2{d_q[3]}};

    always_comb begin
        rsv_v_d = rsv_v_q >> 1;
        rsv_e_d = rsv_e_q >> $bits(ent_t);
        if (acc && is_d) begin
            rsv_v_d[LAT_D-1] = 1'b1;
            rsv_e_d[LAT_D-1] = new_ent;
        end
        if (acc && !is_d) begin
            rsv_v_d[LAT_S-1] = 1'b1;
            rsv_e_d[LAT_S-1] = new_ent;
        end
        d_d = {d_q[2:0], acc && is_d};
        s_d = {s_q[1:0], acc && is_s};
        wp_d = wp_q + AW'(wr);
        rp_d = rp_q + AW'(pop);
        cnt_d = cnt_q + CW'(wr) - CW'(pop);
        cred_d = cred_q + CW'(acc) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsv_v_q <= '0;
            rsv_e_q <= '0;
            d_q <= '0;
            s_q <= '0;
            wp_q <= '0;
            rp_q <= '0;
            cnt_q <= '0;
            cred_q <= '0;
        end else begin
            rsv_v_q <= rsv_v_d;
            rsv_e_q <= rsv_e_d;
            d_q <= d_d;
            s_q <= s_d;
            wp_q <= wp_d;
            rp_q <= rp_d;
            cnt_q <= cnt_d;
            cred_q <= cred_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem_q[wp_q] <= rsv_e_q[0];
    end
endmodule

// File: tb/tb_fmad_sched.sv
// tb_fmad_sched: directed scenarios with an in-order result scoreboard for fmad_sched
module tb_fmad_sched;
    logic clk = 0, reset = 1, req = 0, rslt_rdy = 0;
    logic [31:0] req_command = 0;
    logic [3:0] req_tag = 0;
    logic req_rdy, asel_en, asft_en0, rslt_vld, rslt_sp, rslt_ill, busy;
    logic [3:0] mul_en, asft_en1, rslt_tag;
    logic [1:0] add1_en, add2_en;
    logic [5:0] sb[$];
    logic [5:0] head;
    int n_chk = 0, n_fail = 0, n_acc = 0;

    fmad_sched dut (
        .clk(clk), .reset(reset), .req(req), .req_command(req_command), .req_tag(req_tag),
        .req_rdy(req_rdy), .mul_en(mul_en), .asel_en(asel_en), .asft_en0(asft_en0),
        .asft_en1(asft_en1), .add1_en(add1_en), .add2_en(add2_en), .rslt_vld(rslt_vld),
        .rslt_rdy(rslt_rdy), .rslt_tag(rslt_tag), .rslt_sp(rslt_sp), .rslt_ill(rslt_ill),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] cmd, input logic [3:0] tag);
        req = 1;
        req_command = cmd;
        req_tag = tag;
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && busy; i++) step();
        chk("drain_idle", busy, 0);
        chk("sb_empty", sb.size(), 0);
    endtask

    function automatic logic [31:0] ens();
        return 32'({mul_en, asel_en, asft_en0, asft_en1, add1_en, add2_en});
    endfunction

    // Results are checked in the cycle they are popped
    always @(negedge clk) begin
        if (!reset && rslt_vld && sb.size() == 0) chk("spurious_rslt", rslt_vld, 0);
        else if (!reset && rslt_vld && rslt_rdy) begin
            head = sb.pop_front();
            chk("rslt_head", {rslt_tag, rslt_sp, rslt_ill}, head);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no completion, expected completion");
        $fatal(1);
    end

    initial begin
        step();
        step();
        req = 1;
        #1;
        chk("rst_rdy", req_rdy, 0);
        chk("rst_vld", rslt_vld, 0);
        chk("rst_busy", busy, 0);
        chk("rst_en", ens(), 0);
        req = 0;
        reset = 0;
        rslt_rdy = 1;
        issue(0, 3);
        chk("t1_rdy", req_rdy, 1);
        sb.push_back({4'd3, 2'b00});
        step();
        req = 0;
        chk("t1_c0", ens(), 14'b1111_0_0_0000_00_00);
        step();
        chk("t1_c1", ens(), 14'b0000_1_1_0000_00_00);
        step();
        chk("t1_c2", ens(), 14'b0000_0_0_1111_11_00);
        step();
        chk("t1_c3", ens(), 14'b0000_0_0_0000_00_11);
        step();
        chk("t1_c4_vld", rslt_vld, 0);
        step();
        chk("t1_c5_vld", rslt_vld, 1);
        chk("t1_c5_busy", busy, 1);
        step();
        chk("t1_c6_busy", busy, 0);
        chk("t1_c6_en", ens(), 0);
        drain();

        issue(0, 1);
        chk("t2_fmad_rdy", req_rdy, 1);
        sb.push_back({4'd1, 2'b00});
        step();
        issue(1, 2);
        chk("t2_c1_rdy", req_rdy, 0);
        step();
        chk("t2_c2_rdy", req_rdy, 1);
        sb.push_back({4'd2, 2'b10});
        step();
        req = 0;
        chk("t2_fmas_mul", mul_en, 4'b1001);
        step();
        step();
        chk("t2_c4_vld", rslt_vld, 0);
        step();
        chk("t2_c5_tag", rslt_tag, 1);
        step();
        chk("t2_c6_tag", rslt_tag, 2);
        chk("t2_c6_sp", rslt_sp, 1);
        drain();

        rslt_rdy = 0;
        for (int i = 0; i < 4; i++) begin
            issue(0, 4'(4 + i));
            chk("t3_fill_rdy", req_rdy, 1);
            sb.push_back({4'(4 + i), 2'b00});
            step();
        end
        for (int i = 4; i < 10; i++) begin
            chk("t3_full_rdy", req_rdy, 0);
            if (i >= 6) chk("t3_hold_tag", rslt_tag, 4);
            step();
        end
        rslt_rdy = 1;
        #1;
        chk("t3_c10_rdy", req_rdy, 0);
        step();
        chk("t3_c11_rdy", req_rdy, 1);
        req_tag = 8;
        sb.push_back({4'd8, 2'b00});
        step();
        req = 0;
        drain();

        issue(7, 9);
        chk("t4_rdy", req_rdy, 1);
        sb.push_back({4'd9, 2'b01});
        step();
        req = 0;
        for (int i = 0; i < 4; i++) begin
            chk("t4_no_en", ens(), 0);
            chk("t4_no_vld", rslt_vld, 0);
            step();
        end
        chk("t4_vld", rslt_vld, 1);
        chk("t4_ill", rslt_ill, 1);
        chk("t4_tag", rslt_tag, 9);
        drain();

        issue(0, 5);
        chk("t5_rdy", req_rdy, 1);
        step();
        req = 0;
        step();
        reset = 1;
        req = 1;
        #1;
        chk("t5_rst_rdy", req_rdy, 0);
        req = 0;
        step();
        reset = 0;
        req = 1;
        #1;
        chk("t5_rel_rdy", req_rdy, 1);
        req = 0;
        for (int i = 0; i < 8; i++) begin
            chk("t5_no_en", ens(), 0);
            chk("t5_no_vld", rslt_vld, 0);
            chk("t5_idle", busy, 0);
            step();
        end

        rslt_rdy = 1;
        req = 1;
        req_command = 1;
        n_acc = 0;
        for (int i = 0; i < 200 && n_acc < 20; i++) begin
            req_tag = 4'(n_acc);
            #1;
            if (n_acc < 4) chk("t6_b2b_rdy", req_rdy, 1);
            if (req_rdy) begin
                sb.push_back({4'(n_acc), 2'b10});
                n_acc++;
            end
            step();
        end
        req = 0;
        chk("t6_accepts", n_acc, 20);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
